comm_arb_pipe: RTL and testbench

Buffered, arbitrated successor to the pipelined commutator.
- nIN request channels each carry a data word and a destination address. They are routed to nOUT output endpoints.
- Each input has its own FIFO. Each output has a round-robin arbiter, so address collisions are serialised, not lost.
- Each input has ready backpressure.
- Sits between the input adapter/pre-commutator stage and the output endpoints. A single instance covers the whole nIN x nOUT fabric.

---
 rtl/comm_arb_pipe.sv | 142 ++++++++++++++
 tb/tb_comm_arb_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/comm_arb_pipe.sv
// Buffered nIN x nOUT commutator: per-input FIFOs, per-output round-robin arbiters.
// Optional COMM_ARB_STATS_EN adds per-output grant and per-input stall counters.
module comm_arb_pipe #(
  parameter int unsigned nIN   = 8,
  parameter int unsigned nOUT  = 16,
  parameter int unsigned wD    = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned wA   = $clog2(nOUT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [nIN-1:0]       req_in,
  input  logic [nIN*wD-1:0]    data_in,
  input  logic [nIN*wA-1:0]    addr_in,
  output logic [nIN-1:0]       ready_out,
  output logic [nOUT-1:0]      req_out,
  output logic [nOUT*wD-1:0]   data_out,
  output logic [nIN-1:0]       addr_err,
  output logic [nIN-1:0]       ovf
`ifdef COMM_ARB_STATS_EN
  ,
  output logic [nOUT*16-1:0]   grant_cnt,
  output logic [nIN*16-1:0]    stall_cnt
`endif
);

  localparam int unsigned wI = $clog2(nIN);
  localparam int unsigned wP = $clog2(DEPTH);
  localparam int unsigned wC = wP + 1;

  typedef struct packed {
    logic [wA-1:0] addr;
    logic [wD-1:0] data;
  } entry_t;

  entry_t        mem     [nIN][DEPTH];
  logic [wP-1:0] wr_ptr  [nIN];
  logic [wP-1:0] rd_ptr  [nIN];
  logic [wC-1:0] count   [nIN];
  logic [wI-1:0] rr_ptr  [nOUT];

  entry_t          head      [nIN];
  logic [nIN-1:0]  head_vld;
  logic [nIN-1:0]  head_bad;
  logic [nIN-1:0]  push;
  logic [nIN-1:0]  pop;
  logic [nOUT-1:0] grant_vld;
  logic [wI-1:0]   grant_idx [nOUT];

  // Head view and push qualification; ready comes only from the registered count
  always_comb begin
    head_vld  = '0;
    head_bad  = '0;
    push      = '0;
    ready_out = '0;
    for (int i = 0; i < nIN; i++) begin
      head[i]      = mem[i][rd_ptr[i]];
      head_vld[i]  = (count[i] != '0);
      head_bad[i]  = head_vld[i] && (32'(head[i].addr) >= nOUT);
      ready_out[i] = !reset && (count[i] != wC'(DEPTH));
      push[i]      = req_in[i] && ready_out[i];
    end
  end

  // Round-robin search per output starting at rr_ptr, wrapping modulo nIN
  always_comb begin
    int unsigned idx;
    logic [wI-1:0] sel;
    idx       = 0;
    sel       = '0;
    grant_vld = '0;
    pop       = head_bad;
    for (int o = 0; o < nOUT; o++) grant_idx[o] = '0;
    for (int o = 0; o < nOUT; o++) begin
      for (int k = 0; k < nIN; k++) begin
        idx = 32'(rr_ptr[o]) + 32'(k);
        if (idx >= nIN) idx = idx - nIN;
        sel = wI'(idx);
        if (!grant_vld[o] && head_vld[sel] && !head_bad[sel] &&
            head[sel].addr == wA'(o)) begin
          grant_vld[o] = 1'b1;
          grant_idx[o] = sel;
        end
      end
    end
    for (int o = 0; o < nOUT; o++)
      if (grant_vld[o]) pop[grant_idx[o]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < nIN; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= {addr_in[i*wA +: wA], data_in[i*wD +: wD]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < nIN; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      for (int o = 0; o < nOUT; o++) rr_ptr[o] <= '0;
      req_out  <= '0;
      data_out <= '0;
      addr_err <= '0;
      ovf      <= '0;
    end else begin
      for (int i = 0; i < nIN; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + wP'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + wP'(1);
        count[i] <= count[i] + wC'(push[i]) - wC'(pop[i]);
        if (head_bad[i]) addr_err[i] <= 1'b1;
        if (req_in[i] && !ready_out[i]) ovf[i] <= 1'b1;
      end
      req_out <= grant_vld;
      for (int o = 0; o < nOUT; o++) begin
        if (grant_vld[o]) begin
          data_out[o*wD +: wD] <= head[grant_idx[o]].data;
          rr_ptr[o] <= (32'(grant_idx[o]) == nIN - 1) ? '0 : grant_idx[o] + wI'(1);
        end
      end
    end
  end

`ifdef COMM_ARB_STATS_EN
  // Saturating activity counters
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int o = 0; o < nOUT; o++)
        if (grant_vld[o] && grant_cnt[o*16 +: 16] != 16'hFFFF)
          grant_cnt[o*16 +: 16] <= grant_cnt[o*16 +: 16] + 16'd1;
      for (int i = 0; i < nIN; i++)
        if (head_vld[i] && !head_bad[i] && !pop[i] && stall_cnt[i*16 +: 16] != 16'hFFFF)
          stall_cnt[i*16 +: 16] <= stall_cnt[i*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_comm_arb_pipe.sv
// Self-checking bench for comm_arb_pipe: queue-based reference model plus directed and random traffic.
module tb_comm_arb_pipe;
  localparam int NIN = 8, NOUT = 12, WD = 32, DEPTH = 4, WA = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NIN-1:0]       req_in;
  logic [NIN*WD-1:0]    data_in;
  logic [NIN*WA-1:0]    addr_in;
  logic [NIN-1:0]       ready_out;
  logic [NOUT-1:0]      req_out;
  logic [NOUT*WD-1:0]   data_out;
  logic [NIN-1:0]       addr_err;
  logic [NIN-1:0]       ovf;

  comm_arb_pipe #(.nIN(NIN), .nOUT(NOUT), .wD(WD), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_in(req_in), .data_in(data_in), .addr_in(addr_in),
    .ready_out(ready_out), .req_out(req_out), .data_out(data_out),
    .addr_err(addr_err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] at %0t: got %0h, want %0h", name, idx, $time, act, exp);
    end
  endtask

  // Reference model: one queue per input, one rotating priority per output
  typedef struct packed {
    logic [WA-1:0] a;
    logic [WD-1:0] d;
  } ent_t;

  ent_t            q [NIN][$];
  int              m_ptr [NOUT];
  logic [NOUT-1:0] m_req;
  logic [WD-1:0]   m_data [NOUT];
  logic [NIN-1:0]  m_aerr;
  logic [NIN-1:0]  m_ovf;
  bit              started = 0;

  always @(posedge clk) begin
    logic [NIN-1:0] rdy;
    logic [NIN-1:0] pop;
    int  i;
    bit  found;
    started = 1;
    if (reset) begin
      for (int n = 0; n < NIN; n++) q[n].delete();
      for (int o = 0; o < NOUT; o++) begin m_ptr[o] = 0; m_data[o] = '0; end
      m_req = '0; m_aerr = '0; m_ovf = '0;
    end else begin
      pop = '0;
      for (int n = 0; n < NIN; n++) rdy[n] = (q[n].size() < DEPTH);
      for (int n = 0; n < NIN; n++)
        if (q[n].size() > 0 && q[n][0].a >= NOUT) begin pop[n] = 1'b1; m_aerr[n] = 1'b1; end
      m_req = '0;
      for (int o = 0; o < NOUT; o++) begin
        found = 0;
        for (int k = 0; k < NIN; k++) begin
          i = (m_ptr[o] + k) % NIN;
          if (!found && q[i].size() > 0 && q[i][0].a == o) begin
            found = 1; m_req[o] = 1'b1; m_data[o] = q[i][0].d; pop[i] = 1'b1;
          end
          if (found && k == NIN - 1) ;
        end
        for (int k = 0; k < NIN; k++) begin
          i = (m_ptr[o] + k) % NIN;
          if (m_req[o] && q[i].size() > 0 && q[i][0].a == o && q[i][0].d == m_data[o]) begin
            m_ptr[o] = (i + 1) % NIN;
            break;
          end
        end
      end
      for (int n = 0; n < NIN; n++) if (pop[n]) void'(q[n].pop_front());
      for (int n = 0; n < NIN; n++)
        if (req_in[n]) begin
          if (rdy[n]) q[n].push_back({addr_in[n*WA +: WA], data_in[n*WD +: WD]});
          else m_ovf[n] = 1'b1;
        end
    end
  end

  // Every-cycle compare of the DUT against the model
  always @(negedge clk) begin
    logic [NIN-1:0] er;
    if (started) begin
      for (int n = 0; n < NIN; n++) er[n] = !reset && (q[n].size() < DEPTH);
      chk("ready_out", 0, 64'(ready_out), 64'(er));
      chk("req_out", 0, 64'(req_out), 64'(m_req));
      for (int o = 0; o < NOUT; o++)
        if (m_req[o]) chk("data_out", o, 64'(data_out[o*WD +: WD]), 64'(m_data[o]));
      chk("addr_err", 0, 64'(addr_err), 64'(m_aerr));
      chk("ovf", 0, 64'(ovf), 64'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_push(input int i, input int a, input logic [WD-1:0] d);
    req_in[i] = 1'b1;
    addr_in[i*WA +: WA] = WA'(a);
    data_in[i*WD +: WD] = d;
  endtask

  logic [WD-1:0] burst [3];
  bit            saw_low;
  int            r;

  initial begin
    reset = 1'b1; req_in = '0; data_in = '0; addr_in = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_req_out", 0, 64'(req_out), 64'h0);
    chk("rst_flags", 0, 64'({addr_err, ovf}), 64'h0);
    reset = 1'b0;

    // Single word: input 3 -> output 5, visible two edges after the push
    set_push(3, 5, 32'hA5A5A5A5);
    tick(); req_in = '0;
    @(negedge clk); chk("single_lat1", 0, 64'(req_out), 64'h0);
    tick();
    @(negedge clk); chk("single_req", 0, 64'(req_out), 64'h020);
    chk("single_data", 5, 64'(data_out[5*WD +: WD]), 64'hA5A5A5A5);
    tick();
    @(negedge clk); chk("single_after", 0, 64'(req_out), 64'h0);

    // Collision on output 7, two bursts, each starting at input 0
    for (int b = 0; b < 2; b++) begin
      for (int n = 0; n < 3; n++) begin
        burst[n] = 32'hC0DE0000 + 32'(b * 16 + n);
        set_push(n, 7, burst[n]);
      end
      tick(); req_in = '0;
      for (int n = 0; n < 3; n++) begin
        tick();
        @(negedge clk);
        chk("coll_req", b * 3 + n, 64'(req_out), 64'h080);
        chk("coll_data", b * 3 + n, 64'(data_out[7*WD +: WD]), 64'(32'hC0DE0000 + 32'(b * 16 + n)));
      end
      tick();
      @(negedge clk); chk("coll_idle", b, 64'(req_out), 64'h0);
    end

    // Parallel routes: input i -> output i+4 every cycle
    for (int c = 0; c < 100; c++) begin
      for (int n = 0; n < NIN; n++) set_push(n, n + 4, $urandom);
      tick();
      @(negedge clk);
      if (c >= 1) chk("par_req", c, 64'(req_out), 64'hFF0);
      chk("par_ready", c, 64'(ready_out), 64'hFF);
    end
    req_in = '0;
    tick(); tick();
    @(negedge clk); chk("par_flags", 0, 64'({addr_err, ovf}), 64'h0);

    // Bad address followed by a good one on input 1
    set_push(1, 14, 32'hBAD0BAD0);
    tick();
    set_push(1, 3, 32'h33333333);
    tick(); req_in = '0;
    @(negedge clk);
    chk("bad_err", 0, 64'(addr_err), 64'h02);
    chk("bad_noout", 0, 64'(req_out), 64'h0);
    tick();
    @(negedge clk);
    chk("bad_next_req", 0, 64'(req_out), 64'h008);
    chk("bad_next_data", 3, 64'(data_out[3*WD +: WD]), 64'h33333333);

    // Backpressure: input 4 competes for output 2 with seven other inputs
    saw_low = 0;
    for (int c = 0; c < 6; c++) begin
      for (int n = 0; n < NIN; n++)
        if (n != 4) begin
          req_in[n] = ready_out[n];
          addr_in[n*WA +: WA] = WA'(2);
          data_in[n*WD +: WD] = 32'h22000000 + 32'(n * 256 + c);
        end
      set_push(4, 2, 32'h44000000 + 32'(c));
      tick();
      @(negedge clk);
      if (!ready_out[4]) saw_low = 1;
    end
    req_in = '0;
    chk("bp_ready_low", 0, 64'(saw_low), 64'h1);
    chk("bp_ovf", 0, 64'(ovf), 64'h10);
    repeat (60) tick();

    // Reset with words still buffered on input 0
    for (int c = 0; c < 3; c++) begin
      set_push(0, 9, 32'h90000000 + 32'(c));
      tick();
    end
    req_in = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", 0, 64'(req_out), 64'h0);
    chk("mid_rst_ready", 0, 64'(ready_out), 64'hFF);
    chk("mid_rst_flags", 0, 64'({addr_err, ovf}), 64'h0);
    tick();
    @(negedge clk); chk("mid_rst_drained", 0, 64'(req_out), 64'h0);

    // Randomized traffic with occasional resets and bad addresses
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 249) == 0);
      for (int n = 0; n < NIN; n++) begin
        r = int'($urandom_range(0, 5));
        req_in[n] = (r <= 1) ? 1'b0 : (r <= 4) ? ready_out[n] : 1'b1;
        if ($urandom_range(0, 9) == 0) addr_in[n*WA +: WA] = WA'($urandom_range(12, 15));
        else if ($urandom_range(0, 1) == 0) addr_in[n*WA +: WA] = WA'($urandom_range(0, 3));
        else addr_in[n*WA +: WA] = WA'($urandom_range(0, 11));
        data_in[n*WD +: WD] = $urandom;
      end
      tick();
    end
    reset = 1'b0;
    req_in = '0;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
